// File: rtl/matrix_load_controller.sv
// rtl/matrix_load_controller.sv - byte-serial operand loader and result holder for the convolution coprocessor
module matrix_load_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_size,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic [7:0]   data_in,
    output logic [2:0]   cp_op_code,
    output logic [1:0]   cp_matrix_size,
    output logic [199:0] cp_matrix_a,
    output logic [199:0] cp_matrix_b,
    output logic [199:0] cp_matrix_c,
    input  logic         cp_process_done,
    input  logic [7:0]   cp_result,
    output logic [7:0]   result,
    output logic         result_valid,
    input  logic         result_ack,
    output logic         busy,
    output logic         cmd_error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] LOAD_C = 3'd3;
    localparam logic [2:0] EXEC   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0] state;
    logic [2:0] op_q;
    logic [1:0] size_q;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] last_pos;
    logic [4:0] idx;
    logic [7:0] bit_ofs;
    logic       op_legal;
    logic       last_elem;

    // Only the two defined operations (110, 111) share the upper bits 11.
    assign op_legal  = (cmd_op[2:1] == 2'b11);
    assign last_pos  = {1'b0, size_q} + 3'd1;
    assign last_elem = (row == last_pos) && (col == last_pos);
    assign idx       = ({2'b00, row} * 5'd5) + {2'b00, col};
    assign bit_ofs   = {idx, 3'b000};

    assign cmd_ready      = (state == IDLE);
    assign data_ready     = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
    assign busy           = (state != IDLE);
    assign result_valid   = (state == DONE);
    assign cp_op_code     = (state == EXEC) ? op_q : 3'b000;
    assign cp_matrix_size = size_q;

    // Command capture, element packing, execute handshake and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 3'b000;
            size_q      <= 2'b00;
            row         <= 3'd0;
            col         <= 3'd0;
            cp_matrix_a <= '0;
            cp_matrix_b <= '0;
            cp_matrix_c <= '0;
            result      <= 8'h00;
            cmd_error   <= 1'b0;
        end else begin
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (op_legal) begin
                            op_q        <= cmd_op;
                            size_q      <= cmd_size;
                            cp_matrix_a <= '0;
                            cp_matrix_b <= '0;
                            cp_matrix_c <= '0;
                            row         <= 3'd0;
                            col         <= 3'd0;
                            state       <= LOAD_A;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                LOAD_A, LOAD_B, LOAD_C: begin
                    if (data_valid) begin
                        if (state == LOAD_A)
                            cp_matrix_a[bit_ofs +: 8] <= data_in;
                        else if (state == LOAD_B)
                            cp_matrix_b[bit_ofs +: 8] <= data_in;
                        else
                            cp_matrix_c[bit_ofs +: 8] <= data_in;
                        if (last_elem) begin
                            row <= 3'd0;
                            col <= 3'd0;
                            if (state == LOAD_A)
                                state <= LOAD_B;
                            else if (state == LOAD_B && op_q == 3'b111)
                                state <= LOAD_C;
                            else
                                state <= EXEC;
                        end else if (col == last_pos) begin
                            col <= 3'd0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                EXEC: begin
                    if (cp_process_done) begin
                        result <= cp_result;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_load_controller.md
# matrix_load_controller

Sequential front end for the combinational convolution coprocessor. It accepts a command (operation and matrix size) and a byte-serial stream of matrix elements, then packs them into the three 200-bit operand vectors (image window A, kernel B, kernel C). It drives the coprocessor for one execute phase, captures the saturated 8-bit pixel result, and holds it until the host acknowledges it.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  3  operation: 3'b110 Laplacian, 3'b111 gradient; all other codes are illegal
- cmd_size  input  2  matrix size: 00=2x2, 01=3x3, 10=4x4, 11=5x5
- data_valid  input  1  element byte present
- data_ready  output  1  controller accepts an element this cycle
- data_in  input  8  signed element, two's complement
- cp_op_code  output  3  to coprocessor op_code
- cp_matrix_size  output  2  to coprocessor matrix_size
- cp_matrix_a / cp_matrix_b / cp_matrix_c  output  200 each  packed operands
- cp_process_done  input  1  from coprocessor process_Done
- cp_result  input  8  from coprocessor result_final[7:0]
- result  output  8  captured pixel result
- result_valid  output  1  result held and valid
- result_ack  input  1  host consumed the result
- busy  output  1  state is not IDLE
- cmd_error  output  1  one-cycle pulse when an illegal cmd_op is rejected

## Operation
- Packing: element (r,c) occupies bits [8k+7:8k] with k = 5r+c in each 200-bit vector. Positions with r ≥ n or c ≥ n are 0. n = cmd_size+2.
- Stream order: A row-major (n·n bytes), then B (n·n bytes), then C (n·n bytes, only when op = 111). For op 110, C is left all-zero.
- States:
  - **IDLE**: cmd_ready=1. On cmd_valid:
    - Legal op: latch op and size, clear A/B/C to 0, reset row/col counters, go to LOAD_A.
    - Illegal op: pulse cmd_error for one cycle and stay in IDLE. Latched op and size are unchanged.
  - **LOAD_A / LOAD_B / LOAD_C**: data_ready=1. Each accepted byte (data_valid & data_ready) writes index 5·row+col and increments col. When col reaches n-1, col wraps to 0 and row increments. On the last element (row=n-1, col=n-1), counters clear and the state advances:
    - LOAD_A → LOAD_B.
    - LOAD_B → LOAD_C if op=111, else EXEC.
    - LOAD_C → EXEC.
  - **EXEC**: cp_op_code = latched op. If cp_process_done=1, capture cp_result into result and go to DONE. Otherwise remain in EXEC; there is no timeout.
  - **DONE**: result_valid=1. When result_ack=1, go to IDLE. result_valid is low in the following cycle.
- cp_op_code = 3'b000 in every state except EXEC, so the coprocessor reports process_Done=0 outside execution.
- cp_matrix_size is always the latched size. cp_matrix_a/b/c are always the registered vectors.
- cmd_valid is ignored outside IDLE. data_valid is ignored in IDLE, EXEC and DONE.
- result keeps its value until the next capture. It is not cleared by result_ack or by a new command.

## Timing
- Reset values:
  - State is IDLE, cmd_ready=1, all other handshake outputs are 0.
  - cp_op_code=000, cp_matrix_size=00, all matrices 0, result=0.
  - result_valid=0, busy=0, cmd_error=0.
- Reset asserted in any state returns to IDLE on the next edge and discards partial loads and pending results.
- Throughput: one element per cycle while data_valid is held high, with no bubbles between matrices.
- Latency, with the combinational coprocessor:
  - Last element accepted at edge T.
  - EXEC during cycle T+1, with capture at edge T+2.
  - result_valid high from T+2.
- result_ack arriving in the same cycle that result_valid first rises is honored: the state goes to IDLE on the next edge.
- In IDLE, cmd_ready is combinationally 1. A command arriving in the cycle after the DONE→IDLE transition is accepted.

## Test plan
- **Reset defaults:** assert reset for 2 cycles with random inputs → every output at its reset value; cmd_ready=1.
- **3x3 Laplacian load:**
  - Stimulus: cmd_op=110, cmd_size=01. A = 10,10,10,10,50,10,10,10,10. B = 0,-1,0,-1,4,-1,0,-1,0.
  - Required: cp_matrix_a byte k=6 equals 50 (k = 5r+c), bytes at indices 3,4,8,9,15..24 are 0; cp_matrix_b byte 6 = 0x04; cp_matrix_c = 0.
  - Required: exactly 18 bytes accepted. With the real coprocessor and its kernel orientation, the 3x3 Laplacian reaches a 160 result at cycle T+2.
- **5x5 gradient with stalls:**
  - Stimulus: cmd_op=111, cmd_size=11, 75 bytes with data_valid toggled randomly.
  - Required: busy stays high through the load; byte k of each matrix equals the k-th byte of its segment; EXEC is reached only after the 75th accept.
- **Illegal op:** cmd_op=101 → cmd_error high for exactly 1 cycle, state stays IDLE, data_ready=0, previous result unchanged.
- **Result hold/ack:**
  - Stimulus: hold result_ack=0 for 10 cycles after a result of 0x7F, then pulse result_ack; apply a new command in the next cycle.
  - Required: result_valid=1 and result=0x7F for all 10 cycles; IDLE on the next edge; new command accepted immediately.
- **Reset mid-load:**
  - Stimulus: assert reset after 5 bytes of a 4x4 load.
  - Required: matrices return to 0 and busy=0; a subsequent 2x2 op 110 load of A = 1,2,3,4 places bytes at k = 0,1,5,6.
